// File: rtl/bist_fault_reporter_pkg.sv
// Shared types for the BIST fault-report path: field widths, the buffered
// fault entry and the reporter session states.
package bira_pkg;
  localparam int ROW_W  = 10;
  localparam int COL_W  = 10;
  localparam int BANK_W = 2;
  localparam int IO_W   = 8;

  typedef struct packed {
    logic [BANK_W-1:0] bank;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [IO_W-1:0]   mask;
  } fault_entry_t;

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE, ABORT} rpt_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/bist_fault_reporter_if.sv
// March-engine / BIRA facing signals of the fault reporter.
// master = environment (march engine + BIRA), slave = reporter.
interface bist_fault_reporter_if;
  import bira_pkg::*;
  logic              start;
  logic              cmp_valid;
  logic [ROW_W-1:0]  cmp_row;
  logic [COL_W-1:0]  cmp_col;
  logic [BANK_W-1:0] cmp_bank;
  logic [IO_W-1:0]   cmp_err_mask;
  logic              march_done;
  logic              early_term;
  logic              bist_stall;
  logic              bist_abort;
  logic              fault_detect;
  logic [ROW_W-1:0]  row_add_out;
  logic [COL_W-1:0]  col_add_out;
  logic [IO_W-1:0]   col_flag_out;
  logic [BANK_W-1:0] bank_out;
  logic              test_end;
  logic              overflow;
  logic [7:0]        fault_count;

  modport master (
    output start, cmp_valid, cmp_row, cmp_col, cmp_bank, cmp_err_mask, march_done, early_term,
    input  bist_stall, bist_abort, fault_detect, row_add_out, col_add_out, col_flag_out,
           bank_out, test_end, overflow, fault_count
  );
  modport slave (
    input  start, cmp_valid, cmp_row, cmp_col, cmp_bank, cmp_err_mask, march_done, early_term,
    output bist_stall, bist_abort, fault_detect, row_add_out, col_add_out, col_flag_out,
           bank_out, test_end, overflow, fault_count
  );
endinterface

// File: rtl/bist_fault_reporter_fifo.sv
// Fault-entry FIFO with synchronous flush. A push while full is accepted
// when a pop happens in the same cycle.
module fault_fifo
  import bira_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  fault_entry_t           din,
  input  logic                   pop,
  output fault_entry_t           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  fault_entry_t  mem_q [DEPTH];
  fault_entry_t  mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign dout  = mem_q[rd_q];

  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = din;
        wr_d        = wr_q + AW'(1);
      end
      if (do_pop) rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/bist_fault_reporter.sv
// BIST-side fault-report transmitter: buffers faulty compares and paces them
// to BIRA as single-cycle fault_detect strobes, with drain/abort session control.
module bist_fault_reporter
  import bira_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int REPORT_GAP = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  bist_fault_reporter_if.slave  bus
);
  localparam int CW = $clog2(FIFO_DEPTH);
  localparam int GW = (REPORT_GAP < 1) ? 1 : $clog2(REPORT_GAP + 1);

  rpt_state_e   state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic         fd_q, fd_d, te_q, te_d, abort_q, abort_d, ovf_q, ovf_d;
  logic [7:0]   cnt_q, cnt_d;
  fault_entry_t rep_q, rep_d;

  logic         f_push, f_pop, f_flush, f_full, f_empty, enter_run;
  logic [CW:0]  f_count;
  fault_entry_t f_din, f_dout;

  fault_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (f_flush),
    .push  (f_push),
    .din   (f_din),
    .pop   (f_pop),
    .dout  (f_dout),
    .full  (f_full),
    .empty (f_empty),
    .count (f_count)
  );

  always_comb begin
    f_din  = '{bank: bus.cmp_bank, row: bus.cmp_row, col: bus.cmp_col, mask: bus.cmp_err_mask};
    f_push = (state_q == RUN) && bus.cmp_valid && (bus.cmp_err_mask != '0);
    f_pop  = ((state_q == RUN) || (state_q == DRAIN)) && !f_empty && (gap_q == '0);

    state_d = state_q;
    case (state_q)
      IDLE:        if (bus.start) state_d = RUN;
      RUN:         if (bus.early_term) state_d = ABORT;
                   else if (bus.march_done) state_d = DRAIN;
      DRAIN:       if (bus.early_term) state_d = ABORT;
                   else if (f_empty) state_d = DONE;
      DONE, ABORT: if (bus.start) state_d = RUN;
      default:     state_d = IDLE;
    endcase

    enter_run = (state_d == RUN) && (state_q != RUN);
    // Abort flushes the queue, but a pop on the same edge still gets reported.
    f_flush   = enter_run || ((state_d == ABORT) && (state_q != ABORT));

    fd_d    = f_pop;
    rep_d   = f_pop ? f_dout : rep_q;
    cnt_d   = f_pop ? sat_inc8(cnt_q) : cnt_q;
    gap_d   = f_pop ? GW'(REPORT_GAP) : ((gap_q != '0) ? gap_q - GW'(1) : gap_q);
    ovf_d   = ovf_q || (f_push && f_full && !f_pop);
    te_d    = (state_q == DONE) || (state_q == ABORT);
    abort_d = (state_d == ABORT);
    if (enter_run) begin
      gap_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
      te_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gap_q   <= '0;
      fd_q    <= 1'b0;
      te_q    <= 1'b0;
      abort_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      rep_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      fd_q    <= fd_d;
      te_q    <= te_d;
      abort_q <= abort_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
    end
  end

  assign bus.bist_stall   = (f_count == (CW+1)'(FIFO_DEPTH)) && !f_empty;
  assign bus.bist_abort   = abort_q;
  assign bus.fault_detect = fd_q;
  assign bus.row_add_out  = rep_q.row;
  assign bus.col_add_out  = rep_q.col;
  assign bus.col_flag_out = rep_q.mask;
  assign bus.bank_out     = rep_q.bank;
  assign bus.test_end     = te_q;
  assign bus.overflow     = ovf_q;
  assign bus.fault_count  = cnt_q;
endmodule

// File: tb/tb_bist_fault_reporter.sv
// Bench for bist_fault_reporter: vector table, directed session sequences and
// randomized traffic, all checked against a queue-based reference model.
module tb_bist_fault_reporter;
  import bira_pkg::*;

  localparam int DEPTH = 4;
  localparam int GAP   = 2;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3, M_ABORT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bist_fault_reporter_if bus ();
  bist_fault_reporter #(.FIFO_DEPTH(DEPTH), .REPORT_GAP(GAP)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0, errors = 0, cyc_n = 0;

  // reference model: session state, queued faults, cycles left before next report
  int           m_st, m_gap, m_cnt;
  fault_entry_t m_q[$];
  fault_entry_t m_rep;
  bit           m_fd, m_te, m_ab, m_ov;

  fault_entry_t reps[$];
  int           rep_cyc[$];

  typedef struct {
    bit rst, start, cv;
    logic [9:0] row, col;
    logic [1:0] bank;
    logic [7:0] mask;
    bit md, et;
    bit e_fd;
    logic [9:0] e_row, e_col;
    logic [7:0] e_flag;
    logic [1:0] e_bank;
    bit e_te;
    logic [7:0] e_cnt;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic drive(input bit st, input bit cv, input logic [9:0] r, input logic [9:0] c,
                       input logic [1:0] b, input logic [7:0] m, input bit md, input bit et);
    bus.start = st; bus.cmp_valid = cv; bus.cmp_row = r; bus.cmp_col = c;
    bus.cmp_bank = b; bus.cmp_err_mask = m; bus.march_done = md; bus.early_term = et;
  endtask

  task automatic idle_in();
    drive(0, 0, '0, '0, '0, '0, 0, 0);
  endtask

  function automatic void model_reset();
    m_st = M_IDLE; m_gap = 0; m_cnt = 0; m_q.delete(); m_rep = '0;
    m_fd = 0; m_te = 0; m_ab = 0; m_ov = 0;
  endfunction

  task automatic model_edge();
    fault_entry_t e;
    bit pop, push;
    int nst;
    if (rst) begin model_reset(); return; end
    nst = m_st;
    case (m_st)
      M_IDLE:          if (bus.start) nst = M_RUN;
      M_RUN:           if (bus.early_term) nst = M_ABORT; else if (bus.march_done) nst = M_DRAIN;
      M_DRAIN:         if (bus.early_term) nst = M_ABORT; else if (m_q.size() == 0) nst = M_DONE;
      default:         if (bus.start) nst = M_RUN;
    endcase
    pop  = (m_st == M_RUN || m_st == M_DRAIN) && m_q.size() > 0 && m_gap == 0;
    push = (m_st == M_RUN) && bus.cmp_valid && (bus.cmp_err_mask != 0);
    e    = '{bank: bus.cmp_bank, row: bus.cmp_row, col: bus.cmp_col, mask: bus.cmp_err_mask};
    m_te = (m_st == M_DONE || m_st == M_ABORT);
    m_fd = pop;
    if (pop) begin
      m_rep = m_q.pop_front();
      if (m_cnt < 255) m_cnt++;
      m_gap = GAP;
    end else if (m_gap > 0) m_gap--;
    if (push) begin
      if (m_q.size() < DEPTH) m_q.push_back(e); else m_ov = 1;
    end
    if (nst == M_RUN && m_st != M_RUN) begin
      m_q.delete(); m_ov = 0; m_cnt = 0; m_gap = 0; m_te = 0;
    end
    if (nst == M_ABORT && m_st != M_ABORT) m_q.delete();
    m_ab = (nst == M_ABORT);
    m_st = nst;
  endtask

  function automatic logic [63:0] dut_vec();
    return 64'({bus.fault_detect, bus.row_add_out, bus.col_add_out, bus.col_flag_out, bus.bank_out,
                bus.test_end, bus.bist_stall, bus.overflow, bus.fault_count, bus.bist_abort});
  endfunction

  function automatic logic [63:0] model_vec();
    return 64'({m_fd, m_rep.row, m_rep.col, m_rep.mask, m_rep.bank,
                m_te, (m_q.size() == DEPTH), m_ov, 8'(m_cnt), m_ab});
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk); #1;
    cyc_n++;
    chk("model_outputs", dut_vec(), model_vec());
    chk("test_end_with_fault_detect", 64'(bus.test_end && bus.fault_detect), 64'(0));
    if (bus.fault_detect === 1'b1) begin
      reps.push_back('{bank: bus.bank_out, row: bus.row_add_out, col: bus.col_add_out, mask: bus.col_flag_out});
      rep_cyc.push_back(cyc_n);
    end
  endtask

  task automatic reset_start();
    idle_in(); rst = 1; tick(); rst = 0;
    drive(1, 0, '0, '0, '0, '0, 0, 0); tick(); idle_in();
    reps.delete(); rep_cyc.delete();
  endtask

  task automatic push_n(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      drive(0, 1, 10'(base + i), 10'(i), 2'(i), 8'(i + 1), 0, 0);
      tick();
    end
    idle_in();
  endtask

  task automatic wait_te(input int max_cyc, output int te_cyc);
    int n = 0;
    while (bus.test_end !== 1'b1 && n < max_cyc) begin tick(); n++; end
    te_cyc = cyc_n;
    chk("test_end_within_bound", 64'(bus.test_end), 64'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int te_cyc, sent, guard;
    bit saw_stall;
    model_reset();
    idle_in();
    rst = 1;

    // single fault: IDLE compare ignored, 2-cycle latency, hold, drain, restart, mask==0 ignored
    tbl[0]  = '{1,0,0,10'h000,10'h000,2'd0,8'h00,0,0, 0,10'h000,10'h000,8'h00,2'd0,0,8'd0};
    tbl[1]  = '{0,1,1,10'h3FF,10'h3FF,2'd3,8'hFF,0,0, 0,10'h000,10'h000,8'h00,2'd0,0,8'd0};
    tbl[2]  = '{0,0,1,10'h155,10'h0AA,2'd2,8'h81,0,0, 0,10'h000,10'h000,8'h00,2'd0,0,8'd0};
    tbl[3]  = '{0,0,0,10'h000,10'h000,2'd0,8'h00,0,0, 1,10'h155,10'h0AA,8'h81,2'd2,0,8'd1};
    tbl[4]  = '{0,0,0,10'h000,10'h000,2'd0,8'h00,0,0, 0,10'h155,10'h0AA,8'h81,2'd2,0,8'd1};
    tbl[5]  = '{0,0,0,10'h000,10'h000,2'd0,8'h00,1,0, 0,10'h155,10'h0AA,8'h81,2'd2,0,8'd1};
    tbl[6]  = '{0,0,0,10'h000,10'h000,2'd0,8'h00,0,0, 0,10'h155,10'h0AA,8'h81,2'd2,0,8'd1};
    tbl[7]  = '{0,0,0,10'h000,10'h000,2'd0,8'h00,0,0, 0,10'h155,10'h0AA,8'h81,2'd2,1,8'd1};
    tbl[8]  = '{0,1,0,10'h000,10'h000,2'd0,8'h00,0,0, 0,10'h155,10'h0AA,8'h81,2'd2,0,8'd0};
    tbl[9]  = '{0,0,1,10'h001,10'h002,2'd1,8'h00,0,0, 0,10'h155,10'h0AA,8'h81,2'd2,0,8'd0};
    tbl[10] = '{0,0,0,10'h000,10'h000,2'd0,8'h00,0,0, 0,10'h155,10'h0AA,8'h81,2'd2,0,8'd0};
    for (int i = 0; i < 11; i++) begin
      rst = tbl[i].rst;
      drive(tbl[i].start, tbl[i].cv, tbl[i].row, tbl[i].col, tbl[i].bank, tbl[i].mask, tbl[i].md, tbl[i].et);
      tick();
      chk($sformatf("tbl%0d_fault_detect", i), 64'(bus.fault_detect), 64'(tbl[i].e_fd));
      chk($sformatf("tbl%0d_fields", i), 64'({bus.row_add_out, bus.col_add_out, bus.col_flag_out, bus.bank_out}),
          64'({tbl[i].e_row, tbl[i].e_col, tbl[i].e_flag, tbl[i].e_bank}));
      chk($sformatf("tbl%0d_test_end", i), 64'(bus.test_end), 64'(tbl[i].e_te));
      chk($sformatf("tbl%0d_fault_count", i), 64'(bus.fault_count), 64'(tbl[i].e_cnt));
    end
    rst = 0;

    // burst of 6 with stall honoured: in order, 3 cycles apart, no overflow
    reset_start();
    sent = 0; guard = 0; saw_stall = 0;
    while (sent < 6 && guard < 100) begin
      if (bus.bist_stall) begin saw_stall = 1; idle_in(); end
      else begin drive(0, 1, 10'(16 + sent), 10'(sent), 2'(sent), 8'(sent + 1), 0, 0); sent++; end
      tick(); guard++;
    end
    saw_stall |= bus.bist_stall;
    drive(0, 0, '0, '0, '0, '0, 1, 0); tick(); idle_in();
    wait_te(60, te_cyc);
    chk("burst_stall_seen", 64'(saw_stall), 64'(1));
    chk("burst_reports", 64'(reps.size()), 64'(6));
    for (int i = 0; i < reps.size(); i++) chk($sformatf("burst_row%0d", i), 64'(reps[i].row), 64'(16 + i));
    for (int i = 1; i < rep_cyc.size(); i++)
      chk($sformatf("burst_spacing%0d", i), 64'(rep_cyc[i] - rep_cyc[i-1]), 64'(3));
    chk("burst_overflow", 64'(bus.overflow), 64'(0));

    // stall ignored: 7 pushes in 7 cycles, the 7th finds the FIFO full with no pop
    reset_start();
    push_n(7, 32);
    drive(0, 0, '0, '0, '0, '0, 1, 0); tick(); idle_in();
    wait_te(60, te_cyc);
    chk("ovf_overflow", 64'(bus.overflow), 64'(1));
    chk("ovf_reports", 64'(reps.size()), 64'(6));
    if (reps.size() == 6) chk("ovf_last_row", 64'(reps[5].row), 64'(37));

    // drain with 3 queued
    reset_start();
    push_n(4, 64);
    drive(0, 0, '0, '0, '0, '0, 1, 0); tick(); idle_in();
    wait_te(60, te_cyc);
    chk("drain_reports", 64'(reps.size()), 64'(4));
    if (reps.size() > 0) chk("drain_te_after_last", 64'(te_cyc - rep_cyc[reps.size()-1]), 64'(2));
    chk("drain_abort", 64'(bus.bist_abort), 64'(0));

    // early_term with 3 queued: only the report popped on the abort edge completes
    reset_start();
    push_n(4, 96);
    drive(0, 0, '0, '0, '0, '0, 0, 1); tick(); idle_in();
    for (int i = 0; i < 15; i++) tick();
    chk("abort_reports", 64'(reps.size()), 64'(2));
    chk("abort_flags", 64'({bus.bist_abort, bus.test_end, bus.bist_stall}), 64'(3'b110));
    chk("abort_count", 64'(bus.fault_count), 64'(2));

    // early_term + march_done together, rst mid-DRAIN, fresh session
    reset_start();
    push_n(2, 128);
    drive(0, 0, '0, '0, '0, '0, 1, 1); tick(); idle_in();
    chk("et_md_abort", 64'(bus.bist_abort), 64'(1));
    tick();
    chk("et_md_test_end", 64'(bus.test_end), 64'(1));
    drive(1, 0, '0, '0, '0, '0, 0, 0); tick(); idle_in();
    chk("restart_clears", 64'({bus.bist_abort, bus.test_end, bus.fault_count}), 64'(0));
    push_n(2, 160);
    drive(0, 0, '0, '0, '0, '0, 1, 0); tick(); idle_in();
    rst = 1; tick(); rst = 0;
    chk("rst_mid_drain", dut_vec(), 64'(0));
    drive(1, 0, '0, '0, '0, '0, 0, 0); tick(); idle_in();
    chk("fresh_count", 64'(bus.fault_count), 64'(0));
    push_n(1, 200);
    tick(); tick();
    chk("fresh_report_count", 64'(bus.fault_count), 64'(1));

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 799) == 0);
      bus.start        = ($urandom_range(0, 29) == 0);
      bus.cmp_valid    = ($urandom_range(0, 1) == 1) && !(bus.bist_stall && $urandom_range(0, 3) != 0);
      bus.cmp_row      = 10'($urandom);
      bus.cmp_col      = 10'($urandom);
      bus.cmp_bank     = 2'($urandom);
      bus.cmp_err_mask = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      bus.march_done   = ($urandom_range(0, 59) == 0);
      bus.early_term   = ($urandom_range(0, 149) == 0);
      tick();
    end
    rst = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
